// File: rtl/arith_cmd_ctrl.sv
// Command sequencer: gathers opcode/A/B bytes from the UART, drives the shared
// add/sub datapath, latches the result and returns result + flags bytes.
module arith_cmd_ctrl #(
  parameter int          TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  OP_ADD         = 8'h2B,
  parameter logic [7:0]  OP_SUB         = 8'h2D
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_send,
  input  logic       tx_busy,
  output logic [7:0] dp_a,
  output logic [7:0] dp_b,
  output logic       dp_sub,
  input  logic [7:0] dp_sum,
  input  logic       dp_ovf,
  output logic [7:0] result_q,
  output logic       ovf_q,
  output logic       busy,
  output logic       err_timeout
);

  localparam int             CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     ERR_BYTE = 8'h45;

  typedef enum logic [3:0] {
    IDLE, GET_A, GET_B, EXEC, CAPT,
    SEND_RES, ACK_RES, SEND_FLG, ACK_FLG, SEND_ERR, ACK_ERR
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] tmo_cnt;
  logic             ld_sub, ld_a, ld_b, capt, send, tmo, cnt_clr, cnt_inc;
  logic [7:0]       send_byte;

  assign busy = (state != IDLE);

  always_comb begin
    state_n   = state;
    ld_sub    = 1'b0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    capt      = 1'b0;
    send      = 1'b0;
    send_byte = 8'h00;
    tmo       = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == OP_ADD || rx_data == OP_SUB) begin
            ld_sub  = 1'b1;
            cnt_clr = 1'b1;
            state_n = GET_A;
          end else begin
            state_n = SEND_ERR;
          end
        end
      end
      GET_A, GET_B: begin
        // Timeout takes priority over a byte arriving on the same cycle.
        if (tmo_cnt == CNT_MAX) begin
          tmo     = 1'b1;
          state_n = IDLE;
        end else if (rx_valid) begin
          cnt_clr = 1'b1;
          if (state == GET_A) begin
            ld_a    = 1'b1;
            state_n = GET_B;
          end else begin
            ld_b    = 1'b1;
            state_n = EXEC;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      EXEC: state_n = CAPT;
      CAPT: begin
        capt    = 1'b1;
        state_n = SEND_RES;
      end
      SEND_RES: begin
        if (!tx_busy) begin
          send      = 1'b1;
          send_byte = result_q;
          state_n   = ACK_RES;
        end
      end
      ACK_RES: if (tx_busy) state_n = SEND_FLG;
      SEND_FLG: begin
        if (!tx_busy) begin
          send      = 1'b1;
          send_byte = {7'b0, ovf_q};
          state_n   = ACK_FLG;
        end
      end
      ACK_FLG: if (tx_busy) state_n = IDLE;
      SEND_ERR: begin
        if (!tx_busy) begin
          send      = 1'b1;
          send_byte = ERR_BYTE;
          state_n   = ACK_ERR;
        end
      end
      ACK_ERR: if (tx_busy) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      dp_a        <= 8'h00;
      dp_b        <= 8'h00;
      dp_sub      <= 1'b0;
      result_q    <= 8'h00;
      ovf_q       <= 1'b0;
      tx_send     <= 1'b0;
      tx_data     <= 8'h00;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      tx_send     <= send;
      err_timeout <= tmo;
      if (cnt_clr)      tmo_cnt <= '0;
      else if (cnt_inc) tmo_cnt <= tmo_cnt + 1'b1;
      if (ld_sub) dp_sub <= (rx_data == OP_SUB);
      if (ld_a)   dp_a   <= rx_data;
      if (ld_b)   dp_b   <= rx_data;
      if (capt) begin
        result_q <= dp_sum;
        ovf_q    <= dp_ovf;
      end
      // tx_data stays put through the ACK state until the next send.
      if (send) tx_data <= send_byte;
    end
  end

endmodule

// File: tb/tb_arith_cmd_ctrl.sv
// Scoreboard bench for arith_cmd_ctrl with a behavioural datapath and UART transmitter.
module tb_arith_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_busy = 1'b0;
  logic [7:0] dp_a, dp_b, dp_sum, result_q;
  logic       dp_sub, dp_ovf, ovf_q, busy, err_timeout;
  logic [7:0] bx;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  int         busy_cnt = 0;
  bit         hold_busy = 1'b0;
  int         sends = 0;

  arith_cmd_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
    .dp_a(dp_a), .dp_b(dp_b), .dp_sub(dp_sub), .dp_sum(dp_sum), .dp_ovf(dp_ovf),
    .result_q(result_q), .ovf_q(ovf_q), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Shared add/sub datapath: B is XORed with the subtract select, carry-in = sub.
  assign bx     = dp_b ^ {8{dp_sub}};
  assign dp_sum = dp_a + bx + {7'b0, dp_sub};
  assign dp_ovf = (dp_a[7] == bx[7]) && (dp_sum[7] != dp_a[7]);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Transmitter: consumes each tx_send, checks it against the scoreboard, stays busy briefly.
  initial forever begin
    @(posedge clk); #1;
    if (tx_send) begin
      sends++;
      chk("tx_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("tx_byte", tx_data, exp_q.pop_front());
      busy_cnt = 3;
    end
    if (busy_cnt > 0) busy_cnt--;
    tx_busy = (busy_cnt > 0) || hold_busy;
  end

  task automatic calc(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                      output logic [7:0] r, output logic o);
    int sa, sb, full;
    sa = $signed(a);
    sb = $signed(b);
    full = (op == 8'h2D) ? sa - sb : sa + sb;
    r = 8'(full);
    o = (full > 127) || (full < -128);
  endtask

  task automatic put(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while ((busy || exp_q.size() != 0) && n < 400);
    chk(tag, 32'(busy || exp_q.size() != 0), 0);
  endtask

  task automatic do_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, prev;
    logic       o;
    calc(op, a, b, r, o);
    exp_q.push_back(r);
    exp_q.push_back({7'b0, o});
    prev = result_q;
    @(negedge clk);
    put(op); put(a); put(b);
    @(posedge clk); #1;
    chk("res_early", result_q, prev);
    @(posedge clk); #1;
    chk("res", result_q, r);
    chk("ovf", ovf_q, o);
    chk("dp_sub", dp_sub, (op == 8'h2D));
    wait_idle("cmd_idle");
    chk("busy_end", busy, 0);
  endtask

  initial begin
    logic [7:0] prev;
    int         pulses, idx, s0;

    repeat (3) @(negedge clk);
    chk("rst_tx_send", tx_send, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result_q, 0);
    chk("rst_outs", {tx_data, dp_a, dp_b, dp_sub, ovf_q, err_timeout}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_cmd(8'h2B, 8'h7F, 8'h01);
    do_cmd(8'h2D, 8'h05, 8'h07);
    do_cmd(8'h2D, 8'h80, 8'h01);

    // Unknown opcode
    prev = result_q;
    exp_q.push_back(8'h45);
    @(negedge clk);
    put(8'h2A);
    wait_idle("err_idle");
    chk("err_result", result_q, prev);

    // Inter-byte timeout
    s0 = sends;
    pulses = 0;
    idx = 0;
    @(negedge clk);
    put(8'h2B); put(8'h10);
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #2;
      if (err_timeout) begin
        pulses++;
        idx = i;
      end
    end
    chk("tmo_pulses", pulses, 1);
    chk("tmo_when", 32'(idx >= 15 && idx <= 17), 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_dp_a", dp_a, 8'h10);
    chk("tmo_no_tx", sends, s0);
    do_cmd(8'h2B, 8'h01, 8'h01);

    // Reset during ACK_RES
    exp_q.push_back(8'h07);
    @(negedge clk);
    put(8'h2B); put(8'h03); put(8'h04);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      if (tx_send) break;
    end
    chk("rst_saw_send", tx_send, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_send", tx_send, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_res", {result_q, ovf_q}, 0);
    chk("rst_mid_data", {tx_data, dp_a, dp_b}, 0);
    chk("rst_mid_q", exp_q.size(), 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Backpressure before the flags byte
    exp_q.push_back(8'h0B);
    exp_q.push_back(8'h00);
    s0 = sends;
    @(negedge clk);
    put(8'h2B); put(8'h05); put(8'h06);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      if (sends != s0) break;
    end
    chk("bp_res_sent", sends, s0 + 1);
    hold_busy = 1'b1;
    repeat (50) @(posedge clk);
    #2;
    chk("bp_hold", sends, s0 + 1);
    chk("bp_busy", busy, 1);
    hold_busy = 1'b0;
    wait_idle("bp_idle");
    chk("bp_once", sends, s0 + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
